// File: rtl/traffic_arbiter_n_pkg.sv
// Shared phase encoding and default timing for the N-lane traffic arbiter.
package traffic_system_package;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    localparam int DEF_N_LANES     = 4;
    localparam int DEF_GREEN_SHORT = 30;
    localparam int DEF_GREEN_LONG  = 40;
    localparam int DEF_YELLOW_T    = 3;
    localparam int DEF_ALL_RED_T   = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_arbiter_n_rr_next_lane.sv
// Round-robin successor search: first requesting lane after cur, cur itself last,
// falling back to cur+1 when nobody is requesting.
module rr_next_lane
    import traffic_system_package::*;
#(
    parameter int N_LANES = DEF_N_LANES
) (
    input  logic [N_LANES-1:0]         req,
    input  logic [$clog2(N_LANES)-1:0] cur,
    output logic [$clog2(N_LANES)-1:0] nxt
);

    localparam int LW = $clog2(N_LANES);

    logic [LW-1:0] w_idx;
    logic          w_found;

    // NOTE: every output of this block gets a value before any branch, so no latch can form.
    always_comb begin
        w_idx   = '0;
        w_found = 1'b0;
        nxt     = LW'((int'(cur) + 1) % N_LANES);
        for (int k = 1; k <= N_LANES; k++) begin
            w_idx = LW'((int'(cur) + k) % N_LANES);
            if (!w_found && req[w_idx]) begin
                nxt     = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_arbiter_n.sv
// N-lane traffic light arbiter: green/yellow/all-red cycle with round-robin lane hand-over.
// Optional emergency preemption is compiled in with `define TRAFFIC_PREEMPT_EN.
module traffic_arbiter_n
    import traffic_system_package::*;
#(
    parameter int N_LANES     = DEF_N_LANES,
    parameter int GREEN_SHORT = DEF_GREEN_SHORT,
    parameter int GREEN_LONG  = DEF_GREEN_LONG,
    parameter int YELLOW_T    = DEF_YELLOW_T,
    parameter int ALL_RED_T   = DEF_ALL_RED_T
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_LANES-1:0]          input_ss,
    input  logic [N_LANES-1:0]          input_fs,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                        preempt,
    input  logic [$clog2(N_LANES)-1:0]  preempt_lane,
`endif
    output logic [N_LANES-1:0]          input_red,
    output logic [N_LANES-1:0]          input_green,
    output logic [N_LANES-1:0]          input_yellow,
    output logic [$clog2(N_LANES)-1:0]  grant_lane,
    output logic [1:0]                  phase
);

    localparam int LW = $clog2(N_LANES);
    localparam int TW = $clog2(max_int(max_int(GREEN_SHORT, GREEN_LONG),
                                       max_int(YELLOW_T, ALL_RED_T)) + 1);

    phase_e             r_phase, w_phase_nxt;
    logic [LW-1:0]      r_grant, w_grant_nxt, w_rr_nxt, w_pick;
    logic [TW-1:0]      r_timer, w_timer_nxt;
    logic [N_LANES-1:0] r_red, r_green, r_yellow;
    logic [N_LANES-1:0] w_red_nxt, w_green_nxt, w_yellow_nxt, w_grant_oh, w_next_oh;
    logic               w_other_req, w_pre_away, w_pre_hold;

    rr_next_lane #(.N_LANES(N_LANES)) u_rr (
        .req (input_ss),
        .cur (r_grant),
        .nxt (w_rr_nxt)
    );

    assign w_grant_oh  = N_LANES'(1) << r_grant;
    assign w_other_req = |(input_ss & ~w_grant_oh);

`ifdef TRAFFIC_PREEMPT_EN
    assign w_pre_away = preempt && (preempt_lane != r_grant);
    assign w_pre_hold = preempt && (preempt_lane == r_grant);
    assign w_pick     = preempt ? preempt_lane : w_rr_nxt;
`else
    assign w_pre_away = 1'b0;
    assign w_pre_hold = 1'b0;
    assign w_pick     = w_rr_nxt;
`endif

    // Timer holds remaining cycles minus one; green rests at zero until another lane asks.
    always_comb begin
        w_phase_nxt = r_phase;
        w_grant_nxt = r_grant;
        w_timer_nxt = r_timer;
        case (r_phase)
            PH_GREEN: begin
                if (w_pre_away || (r_timer == '0 && w_other_req && !w_pre_hold)) begin
                    w_phase_nxt = PH_YELLOW;
                    w_timer_nxt = TW'(YELLOW_T - 1);
                end else if (r_timer != '0) begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            PH_YELLOW: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - TW'(1);
                end else begin
                    w_phase_nxt = PH_ALLRED;
                    w_timer_nxt = TW'(ALL_RED_T - 1);
                end
            end
            PH_ALLRED: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - TW'(1);
                end else begin
                    w_phase_nxt = PH_GREEN;
                    w_grant_nxt = w_pick;
                    w_timer_nxt = input_fs[w_pick] ? TW'(GREEN_LONG - 1) : TW'(GREEN_SHORT - 1);
                end
            end
            default: begin
                w_phase_nxt = PH_GREEN;
                w_timer_nxt = TW'(GREEN_SHORT - 1);
            end
        endcase

        w_next_oh    = N_LANES'(1) << w_grant_nxt;
        w_green_nxt  = (w_phase_nxt == PH_GREEN)  ? w_next_oh : '0;
        w_yellow_nxt = (w_phase_nxt == PH_YELLOW) ? w_next_oh : '0;
        w_red_nxt    = ~(w_green_nxt | w_yellow_nxt);
    end

    // Reset loads a full GREEN_SHORT so the first edge after release is green cycle 1.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_GREEN;
            r_grant  <= '0;
            r_timer  <= TW'(GREEN_SHORT);
            r_green  <= N_LANES'(1);
            r_yellow <= '0;
            r_red    <= ~N_LANES'(1);
        end else begin
            r_phase  <= w_phase_nxt;
            r_grant  <= w_grant_nxt;
            r_timer  <= w_timer_nxt;
            r_green  <= w_green_nxt;
            r_yellow <= w_yellow_nxt;
            r_red    <= w_red_nxt;
        end
    end

    assign input_red    = r_red;
    assign input_green  = r_green;
    assign input_yellow = r_yellow;
    assign grant_lane   = r_grant;
    assign phase        = r_phase;

endmodule

// File: tb/tb_traffic_arbiter_n.sv
// Table-driven, scoreboarded bench for traffic_arbiter_n with default parameters (4 lanes).
module tb_traffic_arbiter_n;
    import traffic_system_package::*;

    localparam int GS = 30;
    localparam int GL = 40;
    localparam int YT = 3;
    localparam int AR = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ss, fs;
    logic [3:0] o_red, o_green, o_yellow;
    logic [1:0] o_grant, o_phase;
`ifdef TRAFFIC_PREEMPT_EN
    logic       pre;
    logic [1:0] pre_lane;
`endif

    traffic_arbiter_n dut (
        .clk          (clk),
        .rst          (rst),
        .input_ss     (ss),
        .input_fs     (fs),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt      (pre),
        .preempt_lane (pre_lane),
`endif
        .input_red    (o_red),
        .input_green  (o_green),
        .input_yellow (o_yellow),
        .grant_lane   (o_grant),
        .phase        (o_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ss;
        logic [3:0] fs;
        logic       pre;
        logic [1:0] pre_lane;
        phase_e     ph;
        logic [1:0] lane;
        int         n;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [15:0] exp_out(input phase_e ph, input logic [1:0] lane);
        logic [3:0] g, y;
        g = (ph == PH_GREEN)  ? (4'b0001 << lane) : 4'b0000;
        y = (ph == PH_YELLOW) ? (4'b0001 << lane) : 4'b0000;
        return {ph, lane, g, y, ~(g | y)};
    endfunction

    function automatic logic [15:0] dut_out();
        return {o_phase, o_grant, o_green, o_yellow, o_red};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got ph=%0d lane=%0d g=%b y=%b r=%b, want ph=%0d lane=%0d g=%b y=%b r=%b",
                     name, act[15:14], act[13:12], act[11:8], act[7:4], act[3:0],
                     exp[15:14], exp[13:12], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic add(input logic [3:0] s, input logic [3:0] f, input phase_e ph,
                       input logic [1:0] lane, input int n);
        vec_t v;
        v = '{ss: s, fs: f, pre: 1'b0, pre_lane: 2'd0, ph: ph, lane: lane, n: n};
        tbl.push_back(v);
    endtask

    task automatic add_p(input logic [3:0] s, input logic p, input logic [1:0] pl,
                         input phase_e ph, input logic [1:0] lane, input int n);
        vec_t v;
        v = '{ss: s, fs: 4'b0000, pre: p, pre_lane: pl, ph: ph, lane: lane, n: n};
        tbl.push_back(v);
    endtask

    // Each record's inputs are present at every edge that produces one of its samples.
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                ss = tbl[i].ss;
                fs = tbl[i].fs;
`ifdef TRAFFIC_PREEMPT_EN
                pre      = tbl[i].pre;
                pre_lane = tbl[i].pre_lane;
`endif
                sb_q.push_back(exp_out(tbl[i].ph, tbl[i].lane));
                @(posedge clk);
                @(negedge clk);
                check($sformatf("%s[%0d] cyc%0d", tag, i, c), dut_out(), sb_q.pop_front());
            end
        end
        tbl.delete();
    endtask

    task automatic reset_cycles(input string tag, input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            sb_q.push_back(exp_out(PH_GREEN, 2'd0));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s cyc%0d", tag, c), dut_out(), sb_q.pop_front());
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ss  = 4'b0000;
        fs  = 4'b0000;
`ifdef TRAFFIC_PREEMPT_EN
        pre      = 1'b0;
        pre_lane = 2'd0;
`endif
        @(negedge clk);
        reset_cycles("reset", 3);

        // Full rotation: timing, long green, resting, wrap, empty search, self last.
        add(4'b0010, 4'b0000, PH_GREEN,  2'd0, GS);
        add(4'b0010, 4'b0000, PH_YELLOW, 2'd0, YT);
        add(4'b0010, 4'b0000, PH_ALLRED, 2'd0, AR);
        add(4'b0010, 4'b0000, PH_GREEN,  2'd1, 1);
        add(4'b0010, 4'b0010, PH_GREEN,  2'd1, GS - 1);
        add(4'b0010, 4'b0000, PH_GREEN,  2'd1, 20);
        add(4'b0100, 4'b0000, PH_YELLOW, 2'd1, YT);
        add(4'b0000, 4'b0000, PH_ALLRED, 2'd1, AR);
        add(4'b1100, 4'b0100, PH_GREEN,  2'd2, 1);
        add(4'b1100, 4'b0000, PH_GREEN,  2'd2, GL - 1);
        add(4'b1000, 4'b0000, PH_YELLOW, 2'd2, YT);
        add(4'b1000, 4'b0000, PH_ALLRED, 2'd2, AR);
        add(4'b1000, 4'b0000, PH_GREEN,  2'd3, GS);
        add(4'b0001, 4'b0000, PH_YELLOW, 2'd3, YT);
        add(4'b0001, 4'b0000, PH_ALLRED, 2'd3, AR);
        add(4'b0001, 4'b0000, PH_GREEN,  2'd0, GS);
        add(4'b0100, 4'b0000, PH_YELLOW, 2'd0, YT);
        add(4'b0000, 4'b0000, PH_ALLRED, 2'd0, AR);
        add(4'b0000, 4'b0000, PH_GREEN,  2'd1, GS);
        add(4'b0011, 4'b0000, PH_YELLOW, 2'd1, YT);
        add(4'b0010, 4'b0000, PH_ALLRED, 2'd1, AR);
        add(4'b0010, 4'b0010, PH_GREEN,  2'd1, GL);
        add(4'b0001, 4'b0000, PH_YELLOW, 2'd1, YT);
        add(4'b0001, 4'b0000, PH_ALLRED, 2'd1, AR);
        add(4'b0001, 4'b0000, PH_GREEN,  2'd0, 5);
        run_table("rotate");

        // No demand: lane 0 rests green, then leaves at once when demand shows.
        reset_cycles("reset2", 2);
        add(4'b0000, 4'b0000, PH_GREEN,  2'd0, 210);
        add(4'b0010, 4'b0000, PH_YELLOW, 2'd0, YT);
        add(4'b0010, 4'b0000, PH_ALLRED, 2'd0, AR);
        add(4'b0010, 4'b0000, PH_GREEN,  2'd1, 5);
        run_table("rest");

        // Reset in the middle of lane 2 yellow, then release timing again.
        reset_cycles("reset3", 1);
        add(4'b0100, 4'b0000, PH_GREEN,  2'd0, GS);
        add(4'b0100, 4'b0000, PH_YELLOW, 2'd0, YT);
        add(4'b0100, 4'b0000, PH_ALLRED, 2'd0, AR);
        add(4'b0100, 4'b0000, PH_GREEN,  2'd2, GS);
        add(4'b0001, 4'b0000, PH_YELLOW, 2'd2, 1);
        run_table("to_y2");
        reset_cycles("reset_mid_yellow", 1);
        add(4'b0010, 4'b0000, PH_GREEN,  2'd0, GS);
        add(4'b0010, 4'b0000, PH_YELLOW, 2'd0, YT);
        run_table("after_rst");

`ifdef TRAFFIC_PREEMPT_EN
        reset_cycles("reset4", 1);
        add_p(4'b0000, 1'b0, 2'd0, PH_GREEN,  2'd0, 5);
        add_p(4'b0000, 1'b1, 2'd3, PH_YELLOW, 2'd0, YT);
        add_p(4'b0000, 1'b1, 2'd3, PH_ALLRED, 2'd0, AR);
        add_p(4'b0001, 1'b1, 2'd3, PH_GREEN,  2'd3, 50);
        add_p(4'b0001, 1'b0, 2'd0, PH_YELLOW, 2'd3, YT);
        add_p(4'b0001, 1'b0, 2'd0, PH_ALLRED, 2'd3, AR);
        add_p(4'b0001, 1'b0, 2'd0, PH_GREEN,  2'd0, 5);
        run_table("preempt");
`endif

        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
